// File: rtl/shared_mem_banked_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : shared_mem_pkg                                               |
// | Description : Shared constants and address helpers for shared_mem_banked.  |
// |               Default parameter values, address/bank width derivation and  |
// |               the bank/row split of a low-order-interleaved word address.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package shared_mem_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_MEM_SIZE = 16384;
  localparam int DEF_NPORTS   = 4;
  localparam int DEF_NBANKS   = 4;

  // Word-address width for a memory of mem_size words.
  function automatic int addr_w(input int mem_size);
    return (mem_size > 1) ? $clog2(mem_size) : 1;
  endfunction

  // Bank-select width; zero when there is a single bank.
  function automatic int bank_w(input int nbanks);
    return (nbanks > 1) ? $clog2(nbanks) : 0;
  endfunction

  // Banks are interleaved on the low address bits.
  function automatic int unsigned bank_of(input int unsigned addr, input int unsigned bw);
    return addr & ((32'd1 << bw) - 32'd1);
  endfunction

  // Row inside the selected bank: the remaining upper address bits.
  function automatic int unsigned row_of(input int unsigned addr, input int unsigned bw);
    return addr >> bw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_mem_banked_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : shared_mem_banked_if                                         |
// | Description : Multi-port valid/ready request channel plus one-cycle        |
// |               response strobe. Port p occupies slice p of each vector.     |
// |   req_valid/req_ready/req_we [NPORTS]   request handshake and direction    |
// |   req_addr  [NPORTS*AW]                 word address                       |
// |   req_wdata [NPORTS*XLEN], req_be       write data and byte enables        |
// |   rsp_valid [NPORTS], rsp_rdata         response strobe and read data      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface shared_mem_banked_if #(
  parameter int NPORTS = shared_mem_pkg::DEF_NPORTS,
  parameter int AW     = 14,
  parameter int XLEN   = shared_mem_pkg::DEF_XLEN
);
  logic [NPORTS-1:0]          req_valid;
  logic [NPORTS-1:0]          req_ready;
  logic [NPORTS-1:0]          req_we;
  logic [NPORTS*AW-1:0]       req_addr;
  logic [NPORTS*XLEN-1:0]     req_wdata;
  logic [NPORTS*XLEN/8-1:0]   req_be;
  logic [NPORTS-1:0]          rsp_valid;
  logic [NPORTS*XLEN-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/shared_mem_banked_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Round-robin arbiter. Grants the first requester at or after  |
// |               ptr (wrapping modulo N); on advance with a grant, ptr moves  |
// |               to winner+1.                                                 |
// |   clk, rst_n        clock, asynchronous active-low reset (ptr -> 0)        |
// |   req[N], advance   request vector, commit-grant strobe                    |
// |   grant[N], ptr     one-hot grant, current priority pointer                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic [N-1:0]  req,
  input  wire logic          advance,
  output logic      [N-1:0]  grant,
  output logic      [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic [PW-1:0] nxt;
  logic          found;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    nxt   = ptr_q;
    for (int i = 0; i < N; i++) begin
      idx = PW'((32'(ptr_q) + 32'(i)) % 32'(N));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        nxt        = PW'((32'(idx) + 32'd1) % 32'(N));
      end
    end
    ptr_d = (advance && found) ? nxt : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/shared_mem_banked.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shared_mem_banked                                            |
// | Description : NPORTS-port shared RAM split into NBANKS low-order           |
// |               interleaved banks, one round-robin arbiter per bank. Losing  |
// |               ports stall (req_ready=0); writes honour byte enables; every |
// |               accepted request gets a one-cycle rsp_valid pulse.           |
// |   clk, rst_n   clock, asynchronous active-low reset                        |
// |   bus          shared_mem_banked_if.slave request/response channel         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shared_mem_banked
  import shared_mem_pkg::*;
#(
  parameter int    XLEN      = DEF_XLEN,
  parameter int    MEM_SIZE  = DEF_MEM_SIZE,
  parameter int    NPORTS    = DEF_NPORTS,
  parameter int    NBANKS    = DEF_NBANKS,
  parameter string INIT_FILE = ""
) (
  input wire logic             clk,
  input wire logic             rst_n,
  shared_mem_banked_if.slave   bus
);

  localparam int AW     = addr_w(MEM_SIZE);
  localparam int BW     = bank_w(NBANKS);
  localparam int BSW    = (BW > 0) ? BW : 1;
  localparam int DEPTH  = MEM_SIZE / NBANKS;
  localparam int RW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NBYTES = XLEN / 8;
  localparam int PW     = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  // Per-port address decode.
  logic [BSW-1:0] port_bank [NPORTS];
  logic [RW-1:0]  port_row  [NPORTS];

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      port_bank[p] = BSW'(bank_of(32'(bus.req_addr[p*AW +: AW]), BW));
      port_row[p]  = RW'(row_of(32'(bus.req_addr[p*AW +: AW]), BW));
    end
  end

  logic [NPORTS-1:0] bank_grant [NBANKS];
  logic [XLEN-1:0]   bank_rdata [NBANKS];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [NPORTS-1:0] cand;
    logic [NPORTS-1:0] grant;
    logic [PW-1:0]     ptr;
    logic              bank_en;
    logic              bank_we;
    logic [RW-1:0]     bank_row;
    logic [XLEN-1:0]   bank_wdata;
    logic [NBYTES-1:0] bank_be;
    logic [XLEN-1:0]   bank_dout;
    logic [XLEN-1:0]   mem [DEPTH];

    always_comb begin
      cand = '0;
      for (int p = 0; p < NPORTS; p++)
        cand[p] = bus.req_valid[p] && (port_bank[p] == BSW'(b));
    end

    rr_arbiter #(.N(NPORTS)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (cand),
      .advance (bank_en),
      .grant   (grant),
      .ptr     (ptr)
    );

    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n) (32'(ptr) < 32'(NPORTS)));

    // Route the winning port's request onto the bank.
    always_comb begin
      bank_we    = 1'b0;
      bank_row   = '0;
      bank_wdata = '0;
      bank_be    = '0;
      for (int p = 0; p < NPORTS; p++) begin
        if (grant[p]) begin
          bank_we    = bus.req_we[p];
          bank_row   = port_row[p];
          bank_wdata = bus.req_wdata[p*XLEN +: XLEN];
          bank_be    = bus.req_be[p*NBYTES +: NBYTES];
        end
      end
    end

    // Gated by rst_n so nothing is written while reset is held.
    assign bank_en = (|grant) && rst_n;

    // Single-port RAM with byte-lane write enables and registered read.
    always_ff @(posedge clk) begin
      if (bank_en) begin
        if (bank_we) begin
          for (int k = 0; k < NBYTES; k++)
            if (bank_be[k]) mem[bank_row][k*8 +: 8] <= bank_wdata[k*8 +: 8];
        end else begin
          bank_dout <= mem[bank_row];
        end
      end
    end

    assign bank_grant[b] = grant;
    assign bank_rdata[b] = bank_dout;
  end

  // A port is ready exactly when it wins the bank it addresses.
  logic [NPORTS-1:0] ready;

  always_comb begin
    ready = '0;
    for (int b = 0; b < NBANKS; b++) ready = ready | bank_grant[b];
    ready = ready & {NPORTS{rst_n}};
  end

  assign bus.req_ready = ready;

  // Response bookkeeping: which port completed, whether it read, from which bank.
  logic [NPORTS-1:0]          rsp_valid_q, rsp_valid_d;
  logic [NPORTS-1:0]          rsp_rd_q,    rsp_rd_d;
  logic [NPORTS-1:0][BSW-1:0] rsp_bank_q,  rsp_bank_d;

  always_comb begin
    rsp_valid_d = ready;
    rsp_rd_d    = ~bus.req_we;
    for (int p = 0; p < NPORTS; p++) rsp_bank_d[p] = port_bank[p];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_rd_q    <= '0;
      rsp_bank_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  // Data is forced to zero for write responses and idle cycles.
  logic [NPORTS*XLEN-1:0] rdata_out;

  always_comb begin
    rdata_out = '0;
    for (int p = 0; p < NPORTS; p++)
      if (rsp_valid_q[p] && rsp_rd_q[p])
        rdata_out[p*XLEN +: XLEN] = bank_rdata[rsp_bank_q[p]];
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_out;

endmodule
`default_nettype wire

// File: tb/tb_shared_mem_banked.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shared_mem_banked                                         |
// | Description : Self-checking bench for shared_mem_banked. Directed cases    |
// |               followed by random traffic, all compared cycle by cycle      |
// |               against a word-array / round-robin-pointer reference model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shared_mem_banked;

  localparam int XLEN     = 32;
  localparam int MEM_SIZE = 1024;
  localparam int NPORTS   = 4;
  localparam int NBANKS   = 4;
  localparam int AW       = 10;
  localparam int NB       = XLEN / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shared_mem_banked_if #(.NPORTS(NPORTS), .AW(AW), .XLEN(XLEN)) bus ();

  shared_mem_banked #(
    .XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .NPORTS(NPORTS), .NBANKS(NBANKS), .INIT_FILE("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Requester state: held until the model says it was accepted.
  bit          pv   [NPORTS];
  bit          pwe  [NPORTS];
  int          paddr[NPORTS];
  logic [31:0] pwd  [NPORTS];
  logic [3:0]  pbe  [NPORTS];

  // Reference model.
  logic [31:0] mmem [MEM_SIZE];
  int          mptr [NBANKS];
  bit          erv  [NPORTS];
  logic [31:0] erd  [NPORTS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input bit we, input int a, input logic [31:0] wd, input logic [3:0] be);
    pv[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = wd; pbe[p] = be;
  endtask

  task automatic drive();
    for (int p = 0; p < NPORTS; p++) begin
      bus.req_valid[p]             = pv[p];
      bus.req_we[p]                = pwe[p];
      bus.req_addr[p*AW +: AW]     = AW'(paddr[p]);
      bus.req_wdata[p*XLEN +: XLEN] = pwd[p];
      bus.req_be[p*NB +: NB]       = pbe[p];
    end
  endtask

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int p = 0; p < NPORTS; p++) r |= pv[p];
    return r;
  endfunction

  // One clock: drive, check at negedge, advance the model, end at posedge+1.
  task automatic step();
    bit acc [NPORTS];
    drive();
    @(negedge clk);
    for (int p = 0; p < NPORTS; p++) acc[p] = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      bit found = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
        int q = (mptr[b] + i) % NPORTS;
        if (!found && pv[q] && (paddr[q] % NBANKS) == b) begin
          found   = 1'b1;
          acc[q]  = 1'b1;
          mptr[b] = (q + 1) % NPORTS;
        end
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      check($sformatf("ready[%0d]", p), 32'(bus.req_ready[p]), 32'(acc[p]));
      check($sformatf("rsp_valid[%0d]", p), 32'(bus.rsp_valid[p]), 32'(erv[p]));
      check($sformatf("rsp_rdata[%0d]", p), bus.rsp_rdata[p*XLEN +: XLEN], erv[p] ? erd[p] : 32'h0);
    end
    // Reads see pre-write contents; then apply writes.
    for (int p = 0; p < NPORTS; p++) begin
      erv[p] = acc[p];
      erd[p] = (acc[p] && !pwe[p]) ? mmem[paddr[p]] : 32'h0;
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (acc[p]) begin
        if (pwe[p])
          for (int k = 0; k < NB; k++)
            if (pbe[p][k]) mmem[paddr[p]][8*k +: 8] = pwd[p][8*k +: 8];
        pv[p] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (any_pending() && guard < 20) begin
      step();
      guard++;
    end
    check("drain_timeout", 32'(any_pending()), 32'h0);
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin erv[p] = 1'b0; pv[p] = 1'b0; end
    for (int b = 0; b < NBANKS; b++) mptr[b] = 0;
    #1;
    for (int c = 0; c < ncyc; c++) begin
      bus.req_valid = NPORTS'($urandom);
      bus.req_we    = NPORTS'($urandom);
      bus.req_addr  = (NPORTS*AW)'({$urandom, $urandom});
      bus.req_be    = (NPORTS*NB)'($urandom);
      #1;
      check("rst_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_rdata", 32'(|bus.rsp_rdata), 32'h0);
      @(posedge clk);
      #1;
    end
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int pct);
    for (int p = 0; p < NPORTS; p++)
      if (!pv[p] && $urandom_range(99) < pct)
        set_req(p, 1'($urandom_range(1)), $urandom_range(31), $urandom, 4'($urandom_range(15)));
  endtask

  initial begin
    for (int p = 0; p < NPORTS; p++) begin
      pv[p] = 0; pwe[p] = 0; paddr[p] = 0; pwd[p] = 0; pbe[p] = 0; erd[p] = 0;
    end
    do_reset(3);

    // Preload the working address window with known full words.
    for (int a = 0; a < 32; a++) begin
      set_req(0, 1'b1, a, $urandom, 4'hF);
      step();
    end
    step();

    // First read after reset.
    set_req(0, 1'b0, 5, 32'h0, 4'h0);
    step();
    step();

    // Byte strobes on port 1.
    set_req(1, 1'b1, 8, 32'hAABBCCDD, 4'hF); step();
    set_req(1, 1'b1, 8, 32'h11223344, 4'h5); step();
    set_req(1, 1'b0, 8, 32'h0, 4'h0);        step();
    check("strobe_merge", bus.rsp_rdata[1*XLEN +: XLEN], 32'hAA22CC44);
    step();

    // Four ports on four distinct banks in one cycle.
    for (int p = 0; p < NPORTS; p++) set_req(p, 1'b0, p, 32'h0, 4'h0);
    step();
    check("parallel_ready", 32'(bus.rsp_valid), 32'hF);
    step();

    // All ports contend for bank 0 straight out of reset.
    do_reset(1);
    for (int p = 0; p < NPORTS; p++) set_req(p, 1'b0, 4*p, 32'h0, 4'h0);
    drain();
    step();

    // Write/read collision on the same word.
    set_req(0, 1'b1, 4, 32'hDEAD0001, 4'hF);
    set_req(2, 1'b0, 4, 32'h0, 4'h0);
    drain();
    check("collide_rd", bus.rsp_rdata[2*XLEN +: XLEN], 32'hDEAD0001);
    step();

    // Reset right after a read is accepted; earlier write must survive.
    set_req(0, 1'b0, 7, 32'h0, 4'h0);
    step();
    do_reset(2);
    set_req(3, 1'b0, 4, 32'h0, 4'h0);
    step();
    check("persist_rd", bus.rsp_rdata[3*XLEN +: XLEN], 32'hDEAD0001);
    step();

    // Random mixed traffic.
    for (int c = 0; c < 400; c++) begin
      gen(60);
      step();
    end
    drain();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
